// File: rtl/pair_packer.sv
// pair_packer: gathers consecutive stream elements into two-element pairs
// (first element in the low half) and buffers the pairs in a small FIFO
// whose head drives the registered output.
// Optional feature: define PAIR_PACKER_FLUSH_EN to add a flush input that
// pushes a lone held element as {0, hold}.
module pair_packer #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WORD_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [2*WORD_W-1:0]          out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         half_pending,
  output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef PAIR_PACKER_FLUSH_EN
  ,
  input  logic                         flush
`endif
);

  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_t;

  state_t               state;
  logic [WORD_W-1:0]    hold;
  logic [2*WORD_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [LVL_W-1:0]     count;

  logic                 in_fire;
  logic                 out_fire;
  logic                 push;
  logic                 pop;
  logic                 flush_push;
  logic [2*WORD_W-1:0]  push_data;

  assign out_valid    = (count != '0);
  assign out_data     = mem[rd_ptr];
  assign level        = count;
  assign half_pending = (state == HALF);

  // Handshake decode: a push into a full FIFO is allowed when a pop happens in the same cycle.
  always_comb begin
    out_fire   = out_valid & out_ready;
    in_ready   = (state == EMPTY) | (count < LVL_W'(DEPTH)) | out_fire;
    in_fire    = in_valid & in_ready;
    flush_push = 1'b0;
`ifdef PAIR_PACKER_FLUSH_EN
    // A flush only takes effect when no real partner arrives and the FIFO can take a pair.
    flush_push = flush & (state == HALF) & ~in_fire & in_ready;
`endif
    push       = ((state == HALF) & in_fire) | flush_push;
    pop        = out_fire;
    push_data  = flush_push ? {{WORD_W{1'b0}}, hold} : {in_data, hold};
  end

  // Pair storage; contents need no reset since out_data is only meaningful while out_valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pairing FSM, FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      hold   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            hold  <= in_data;
            state <= HALF;
          end
        end
        HALF: begin
          if (in_fire || flush_push) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase

      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pair_packer.sv
// Directed and randomized checks for pair_packer (default parameters).
module tb_pair_packer;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        half_pending;
  logic [1:0]  level;
`ifdef PAIR_PACKER_FLUSH_EN
  logic        flush;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pair_packer #(.WORD_W(32), .DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .half_pending (half_pending),
    .level        (level)
`ifdef PAIR_PACKER_FLUSH_EN
    ,
    .flush        (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [63:0] sb[$];
  logic [31:0] held;
  logic        model_half;
  int          sent;
  int          cycles;
  logic        done;

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
`ifdef PAIR_PACKER_FLUSH_EN
    flush     = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_half", 64'(half_pending), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Basic pair with consumer ready
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h3;
    tick();
    check("basic_half", 64'(half_pending), 64'd1);
    check("basic_lvl0", 64'(level), 64'd0);
    in_data = 32'h5;
    tick();
    in_valid = 1'b0;
    #1;
    check("basic_valid", 64'(out_valid), 64'd1);
    check("basic_data", out_data, 64'h0000000500000003);
    check("basic_lvl1", 64'(level), 64'd1);
    tick();
    check("basic_lvl_after", 64'(level), 64'd0);
    check("basic_valid_after", 64'(out_valid), 64'd0);

    // Back-pressure: six words with consumer stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int w = 1; w <= 5; w++) begin
      in_data = 32'(w);
      tick();
    end
    in_data = 32'd6;
    #1;
    check("bp_level", 64'(level), 64'd2);
    check("bp_half", 64'(half_pending), 64'd1);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    tick();
    check("bp_hold_level", 64'(level), 64'd2);
    check("bp_hold_half", 64'(half_pending), 64'd1);
    out_ready = 1'b1;
    #1;
    check("bp_ready_w_pop", 64'(in_ready), 64'd1);
    check("bp_head1", out_data, 64'h0000000200000001);
    tick();
    in_valid = 1'b0;
    #1;
    check("simul_level", 64'(level), 64'd2);
    check("simul_half", 64'(half_pending), 64'd0);
    check("bp_head2", out_data, 64'h0000000400000003);
    tick();
    check("bp_head3", out_data, 64'h0000000600000005);
    check("bp_lvl_1", 64'(level), 64'd1);
    tick();
    check("bp_drained", 64'(level), 64'd0);

    // Stalled output holds its value
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    tick();
    in_data   = 32'h22;
    tick();
    in_valid  = 1'b0;
    tick();
    tick();
    check("stall_stable", out_data, 64'h0000002200000011);
    check("stall_valid", 64'(out_valid), 64'd1);

    // Reset mid-operation (HALF with level 1); in_fire during reset ignored
    in_valid = 1'b1;
    in_data  = 32'h9;
    tick();
    check("pre_rst_half", 64'(half_pending), 64'd1);
    rst     = 1'b1;
    in_data = 32'h77;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_half", 64'(half_pending), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    in_data   = 32'hB;
    tick();
    in_valid  = 1'b0;
    #1;
    check("post_rst_pair", out_data, 64'h0000000B0000000A);
    tick();
    check("post_rst_drained", 64'(level), 64'd0);

`ifdef PAIR_PACKER_FLUSH_EN
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h7;
    tick();
    in_valid  = 1'b0;
    flush     = 1'b1;
    tick();
    check("flush_data", out_data, 64'h0000000000000007);
    check("flush_half", 64'(half_pending), 64'd0);
    check("flush_level", 64'(level), 64'd1);
    out_ready = 1'b1;
    tick();
    tick();
    check("flush_empty_valid", 64'(out_valid), 64'd0);
    check("flush_empty_level", 64'(level), 64'd0);
    flush = 1'b0;
`endif

    // Randomized traffic against a scoreboard
    sent       = 0;
    cycles     = 0;
    model_half = 1'b0;
    held       = '0;
    done       = 1'b0;
    while (cycles < 60000) begin
      if (sent >= 10000 && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
      in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("rand_spurious", 64'(out_valid), 64'd0);
        end else begin
          check("rand_pair", out_data, sb.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        if (model_half) sb.push_back({in_data, held});
        else held = in_data;
        model_half = ~model_half;
        sent++;
      end
      tick();
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rand_done", 64'(done), 64'd1);
    check("rand_level", 64'(level), 64'd0);
    check("rand_half", 64'(half_pending), 64'(model_half));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
